decode_in_txn_capture: RTL and testbench

DECODE_IN_TXN_CAPTURE -- requirements
Module: decode_in_txn_capture

---
 rtl/decode_in_capture_pkg.sv | 29 ++
 rtl/decode_in_capture_fifo.sv | 60 ++++++
 rtl/decode_in_txn_capture.sv | 132 +++++++++++++
 tb/tb_decode_in_txn_capture.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_in_capture_pkg.sv
// rtl/decode_in_capture_pkg.sv - shared types, defaults and helpers for decode_in_txn_capture
// Record timestamps are compiled in only with DECODE_IN_CAPTURE_TS_EN defined.
package decode_in_capture_pkg;

    localparam int DEF_INSTR_W = 16;
    localparam int DEF_PC_W    = 16;
    localparam int DEF_DEPTH   = 8;
    localparam int DEF_TS_W    = 32;
    localparam int DEF_MODE    = 0;

    typedef enum logic [1:0] {
        ST_PRIME  = 2'd0,
        ST_ARMED  = 2'd1,
        ST_PAUSED = 2'd2
    } cap_state_e;

    typedef struct packed {
`ifdef DECODE_IN_CAPTURE_TS_EN
        logic [DEF_TS_W-1:0]    ts;
`endif
        logic [DEF_INSTR_W-1:0] instr;
        logic [DEF_PC_W-1:0]    npc;
    } cap_rec_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/decode_in_capture_fifo.sv
// rtl/decode_in_capture_fifo.sv - synchronous record FIFO with flush and occupancy output
module decode_in_capture_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   flush,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             wr_fire, rd_fire;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign level   = wr_ptr_q - rd_ptr_q;
    assign empty   = (level == '0);
    assign full    = (level == FULL_LVL);
    assign rd_fire = rd_en && !empty && !flush;
    assign wr_fire = wr_en && !flush && (!full || rd_fire);
    assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (wr_fire) wr_ptr_d = wr_ptr_q + 1'b1;
            if (rd_fire) rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_fire) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/decode_in_txn_capture.sv
// rtl/decode_in_txn_capture.sv - captures decode-stage instruction/next-PC transactions into a record FIFO
// Optional per-record timestamp and rec_ts port via DECODE_IN_CAPTURE_TS_EN.
module decode_in_txn_capture
    import decode_in_capture_pkg::*;
#(
    parameter int INSTR_W = DEF_INSTR_W,
    parameter int PC_W    = DEF_PC_W,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int TS_W    = DEF_TS_W,
    parameter int MODE    = DEF_MODE
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [INSTR_W-1:0]     dout,
    input  logic [PC_W-1:0]        npc_in,
    input  logic                   enable_decode,
    input  logic                   cap_en,
    input  logic                   flush,
    output logic                   rec_valid,
    input  logic                   rec_ready,
    output logic [INSTR_W-1:0]     rec_instr,
    output logic [PC_W-1:0]        rec_npc,
`ifdef DECODE_IN_CAPTURE_TS_EN
    output logic [TS_W-1:0]        rec_ts,
`endif
    output logic [15:0]            drop_cnt,
    output logic [$clog2(DEPTH):0] level
);

    localparam int OBS_W = INSTR_W + PC_W;
`ifdef DECODE_IN_CAPTURE_TS_EN
    localparam int REC_W = OBS_W + TS_W;
`else
    localparam int REC_W = OBS_W;
`endif

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TS_W < 1 || MODE < 0 || MODE > 1) begin : g_bad_cfg
        $error("decode_in_txn_capture: unsupported DEPTH/TS_W/MODE");
    end

    cap_state_e       state_q, state_d;
    logic [OBS_W-1:0] prev_q, prev_d;
    logic [OBS_W-1:0] cur_obs;
    logic [15:0]      drop_q, drop_d;
    logic             capture, pop, dropped, wr_en;
    logic             fifo_empty, fifo_full;
    logic [REC_W-1:0] wr_data, rd_data;

`ifdef DECODE_IN_CAPTURE_TS_EN
    logic [TS_W-1:0]  ts_q, ts_d;
`endif

    assign cur_obs = {dout, npc_in};

    always_comb begin
        state_d = state_q;
        prev_d  = prev_q;
        capture = 1'b0;
        unique case (state_q)
            ST_PRIME: begin
                if (cap_en) begin
                    prev_d  = cur_obs;
                    state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                // prev tracks the bus on every armed cycle, even the one that pauses.
                prev_d = cur_obs;
                if (!cap_en)        state_d = ST_PAUSED;
                else if (MODE == 0) capture = (cur_obs != prev_q);
                else                capture = enable_decode;
            end
            ST_PAUSED: begin
                if (cap_en) state_d = ST_PRIME;
            end
            default: state_d = ST_PRIME;
        endcase
    end

    // A pop frees a slot in the same edge, so a full FIFO still takes the capture.
    assign rec_valid = !fifo_empty;
    assign pop       = rec_valid && rec_ready;
    assign dropped   = capture && !flush && fifo_full && !pop;
    assign wr_en     = capture && !flush;
    assign drop_d    = dropped ? sat_inc16(drop_q) : drop_q;
    assign drop_cnt  = drop_q;

`ifdef DECODE_IN_CAPTURE_TS_EN
    assign ts_d      = ts_q + 1'b1;
    assign wr_data   = {ts_q, cur_obs};
    assign rec_ts    = rd_data[OBS_W +: TS_W];
`else
    assign wr_data   = cur_obs;
`endif
    assign rec_instr = rd_data[PC_W +: INSTR_W];
    assign rec_npc   = rd_data[PC_W-1:0];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_PRIME;
            prev_q  <= '0;
            drop_q  <= '0;
`ifdef DECODE_IN_CAPTURE_TS_EN
            ts_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            prev_q  <= prev_d;
            drop_q  <= drop_d;
`ifdef DECODE_IN_CAPTURE_TS_EN
            ts_q    <= ts_d;
`endif
        end
    end

    decode_in_capture_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .flush   (flush),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (pop),
        .rd_data (rd_data),
        .empty   (fifo_empty),
        .full    (fifo_full),
        .level   (level)
    );

endmodule

// File: tb/tb_decode_in_txn_capture.sv
// tb/tb_decode_in_txn_capture.sv - self-checking bench: MODE 0 and MODE 1 instances against a queue model
module tb_decode_in_txn_capture;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] npc;
        logic [31:0] ts;
    } mrec_t;

    logic        clock;
    logic        rst_n [2];
    logic [15:0] din   [2];
    logic [15:0] npc   [2];
    logic        en    [2];
    logic        cen   [2];
    logic        fl    [2];
    logic        rdy   [2];
    logic        vld   [2];
    logic [15:0] ins   [2];
    logic [15:0] onpc  [2];
    logic [31:0] ots   [2];
    logic [15:0] drp   [2];
    logic [3:0]  lvl   [2];

    int n_tests = 0;
    int n_fail  = 0;

    mrec_t       mq    [2][$];
    int          mph   [2];
    logic [31:0] mprev [2];
    logic [31:0] mts   [2];
    logic [15:0] mdrop [2];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    decode_in_txn_capture #(.MODE(0)) u_dut0 (
        .clock(clock), .reset_n(rst_n[0]), .dout(din[0]), .npc_in(npc[0]),
        .enable_decode(en[0]), .cap_en(cen[0]), .flush(fl[0]),
        .rec_valid(vld[0]), .rec_ready(rdy[0]), .rec_instr(ins[0]), .rec_npc(onpc[0]),
`ifdef DECODE_IN_CAPTURE_TS_EN
        .rec_ts(ots[0]),
`endif
        .drop_cnt(drp[0]), .level(lvl[0])
    );

    decode_in_txn_capture #(.MODE(1)) u_dut1 (
        .clock(clock), .reset_n(rst_n[1]), .dout(din[1]), .npc_in(npc[1]),
        .enable_decode(en[1]), .cap_en(cen[1]), .flush(fl[1]),
        .rec_valid(vld[1]), .rec_ready(rdy[1]), .rec_instr(ins[1]), .rec_npc(onpc[1]),
`ifdef DECODE_IN_CAPTURE_TS_EN
        .rec_ts(ots[1]),
`endif
        .drop_cnt(drp[1]), .level(lvl[1])
    );

`ifndef DECODE_IN_CAPTURE_TS_EN
    initial begin
        ots[0] = '0;
        ots[1] = '0;
    end
`endif

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic model_reset(input int k);
        mph[k]   = 0;
        mprev[k] = '0;
        mts[k]   = '0;
        mdrop[k] = '0;
        mq[k].delete();
    endtask

    // Phases: 0 priming, 1 armed, 2 paused.
    task automatic model_step(input int k);
        logic [31:0] cur;
        bit          cap;
        bit          pop;
        mrec_t       r;
        cur = {din[k], npc[k]};
        cap = 1'b0;
        pop = (mq[k].size() != 0) && rdy[k];
        case (mph[k])
            0: if (cen[k]) begin mprev[k] = cur; mph[k] = 1; end
            1: begin
                if (!cen[k])     mph[k] = 2;
                else if (k == 0) cap = (cur != mprev[k]);
                else             cap = en[k];
                mprev[k] = cur;
            end
            default: if (cen[k]) mph[k] = 0;
        endcase
        r = '{instr: din[k], npc: npc[k], ts: mts[k]};
        if (fl[k]) begin
            mq[k].delete();
        end else if (cap && mq[k].size() == 8 && !pop) begin
            if (mdrop[k] != 16'hFFFF) mdrop[k]++;
        end else begin
            if (pop) void'(mq[k].pop_front());
            if (cap) mq[k].push_back(r);
        end
        mts[k] = mts[k] + 1;
    endtask

    always @(posedge clock) begin
        for (int k = 0; k < 2; k++)
            if (rst_n[k]) model_step(k);
    end

    always @(negedge clock) begin
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("u%0d.rec_valid", k), 32'(vld[k]), 32'(mq[k].size() != 0));
            chk($sformatf("u%0d.level", k), 32'(lvl[k]), 32'(mq[k].size()));
            chk($sformatf("u%0d.drop_cnt", k), 32'(drp[k]), 32'(mdrop[k]));
            if (mq[k].size() != 0) begin
                chk($sformatf("u%0d.rec_instr", k), 32'(ins[k]), 32'(mq[k][0].instr));
                chk($sformatf("u%0d.rec_npc", k), 32'(onpc[k]), 32'(mq[k][0].npc));
`ifdef DECODE_IN_CAPTURE_TS_EN
                chk($sformatf("u%0d.rec_ts", k), ots[k], mq[k][0].ts);
`endif
            end
        end
    end

    task automatic tick();
        @(negedge clock);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            rst_n[k] = 1'b0; din[k] = '0; npc[k] = '0; en[k] = 1'b0;
            cen[k] = 1'b0; fl[k] = 1'b0; rdy[k] = 1'b0;
            model_reset(k);
        end
        repeat (2) @(negedge clock);
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;

        // Priming cycle with constant bus: nothing captured.
        cen[0] = 1'b1; din[0] = 16'h1234; npc[0] = 16'h3001;
        repeat (3) tick();
        chk("prime.level", 32'(lvl[0]), 32'd0);
        chk("prime.valid", 32'(vld[0]), 32'd0);

        // First change: record visible one edge later, ts = edge index 3.
        din[0] = 16'h5678;
        tick();
        chk("chg.valid", 32'(vld[0]), 32'd1);
        chk("chg.instr", 32'(ins[0]), 32'h5678);
        chk("chg.npc", 32'(onpc[0]), 32'h3001);
`ifdef DECODE_IN_CAPTURE_TS_EN
        chk("chg.ts", ots[0], 32'd3);
`endif

        fl[0] = 1'b1;
        tick();
        fl[0] = 1'b0;
        chk("flush.level", 32'(lvl[0]), 32'd0);

        // Ten changes into an 8-deep FIFO with no consumer.
        for (int i = 0; i < 10; i++) begin
            din[0] = 16'h0100 + 16'(i);
            tick();
        end
        chk("full.level", 32'(lvl[0]), 32'd8);
        chk("full.drop", 32'(drp[0]), 32'd2);

        // Capture and pop on the same edge while full.
        rdy[0] = 1'b1;
        din[0] = 16'h0200;
        tick();
        chk("fullpop.level", 32'(lvl[0]), 32'd8);
        chk("fullpop.drop", 32'(drp[0]), 32'd2);
        for (int j = 0; j < 8; j++) begin
            chk($sformatf("order%0d", j), 32'(ins[0]), (j < 7) ? 32'h0101 + 32'(j) : 32'h0200);
            tick();
        end
        chk("drain.level", 32'(lvl[0]), 32'd0);

        // Mid-stream asynchronous reset with five queued records.
        rdy[0] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            din[0] = 16'h0300 + 16'(i);
            tick();
        end
        chk("pre_rst.level", 32'(lvl[0]), 32'd5);
        #2;
        rst_n[0] = 1'b0;
        model_reset(0);
        #1;
        chk("rst.valid", 32'(vld[0]), 32'd0);
        chk("rst.level", 32'(lvl[0]), 32'd0);
        chk("rst.drop", 32'(drp[0]), 32'd0);
        tick();
        rst_n[0] = 1'b1;
        din[0] = 16'h0400;
        tick();
        chk("reprime.level", 32'(lvl[0]), 32'd0);
        din[0] = 16'h0401;
        tick();
        chk("rearmed.level", 32'(lvl[0]), 32'd1);
        chk("rearmed.instr", 32'(ins[0]), 32'h0401);

        // Flush discards a same-cycle capture without counting a drop.
        din[0] = 16'h0402;
        fl[0] = 1'b1;
        tick();
        fl[0] = 1'b0;
        chk("flushcap.level", 32'(lvl[0]), 32'd0);
        chk("flushcap.drop", 32'(drp[0]), 32'd0);

        // Pause, then re-prime before captures resume.
        cen[0] = 1'b0;
        tick();
        din[0] = 16'h0500;
        tick();
        chk("paused.level", 32'(lvl[0]), 32'd0);
        cen[0] = 1'b1;
        tick();
        din[0] = 16'h0501;
        tick();
        chk("paused_prime.level", 32'(lvl[0]), 32'd0);
        din[0] = 16'h0502;
        tick();
        chk("resume.level", 32'(lvl[0]), 32'd1);
        chk("resume.instr", 32'(ins[0]), 32'h0502);
        rdy[0] = 1'b1;
        tick();

        // MODE 1: three enabled cycles of constant data, fresh timestamp base.
        #2;
        rst_n[1] = 1'b0;
        model_reset(1);
        tick();
        rst_n[1] = 1'b1;
        cen[1] = 1'b1; din[1] = 16'hABCD; npc[1] = 16'h0042;
        repeat (2) tick();
        en[1] = 1'b1;
        repeat (3) tick();
        en[1] = 1'b0;
        tick();
        chk("m1.level", 32'(lvl[1]), 32'd3);
        rdy[1] = 1'b1;
        for (int j = 0; j < 3; j++) begin
            chk($sformatf("m1.instr%0d", j), 32'(ins[1]), 32'hABCD);
            chk($sformatf("m1.npc%0d", j), 32'(onpc[1]), 32'h0042);
`ifdef DECODE_IN_CAPTURE_TS_EN
            chk($sformatf("m1.ts%0d", j), ots[1], 32'd2 + 32'(j));
`endif
            tick();
        end
        chk("m1.drain", 32'(lvl[1]), 32'd0);

        repeat (2) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
